// File: rtl/execute_mc.sv
// Registered MIPS execute stage with valid/ready handshakes and an iterative
// shift-add multiplier / restoring divider feeding the HI/LO registers.
module execute_mc #(
  parameter int WIDTH = 32,
  parameter int SH_W  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] read_data1,
  input  logic [WIDTH-1:0] read_data2,
  input  logic [WIDTH-1:0] immediate,
  input  logic [5:0]       funct,
  input  logic [2:0]       alu_op,
  input  logic             alu_src,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state, state_nx;

  logic [WIDTH-1:0]   b, res, a_mag, b_mag, dvsr, div_dif, div_rem, done_hi, done_lo;
  logic [SH_W-1:0]    shamt, count;
  logic [2*WIDTH-1:0] acc, prod_fix;
  logic [WIDTH:0]     mul_sum, div_sh;
  logic               accept, is_md, a_neg, b_neg, div_ge;
  logic               neg_q, neg_r, div0, is_div;

  assign b      = alu_src ? immediate : read_data2;
  assign shamt  = immediate[6+SH_W-1:6];
  assign accept = in_valid && in_ready;
  assign is_md  = (alu_op == 3'b010) && (funct[5:2] == 4'b0110);

  // Signed MULT/DIV work on magnitudes; funct[0] marks the unsigned variants.
  assign a_neg = !funct[0] && read_data1[WIDTH-1];
  assign b_neg = !funct[0] && b[WIDTH-1];
  assign a_mag = a_neg ? -read_data1 : read_data1;
  assign b_mag = b_neg ? -b : b;

  always_comb begin
    res = '0;
    case (alu_op)
      3'b000: res = read_data1 + b;
      3'b001: res = read_data1 - b;
      3'b011: res = read_data1 & b;
      3'b100: res = read_data1 | b;
      3'b101: res = WIDTH'($signed(read_data1) < $signed(b));
      3'b110: res = b << 16;
      3'b111: res = read_data1 ^ b;
      default: begin
        case (funct)
          6'b100000: res = read_data1 + b;
          6'b100010: res = read_data1 - b;
          6'b100100: res = read_data1 & b;
          6'b100101: res = read_data1 | b;
          6'b100110: res = read_data1 ^ b;
          6'b100111: res = ~(read_data1 | b);
          6'b101010: res = WIDTH'($signed(read_data1) < $signed(b));
          6'b101011: res = WIDTH'(read_data1 < b);
          6'b000000: res = b << shamt;
          6'b000010: res = b >> shamt;
          6'b000011: res = $signed(b) >>> shamt;
          6'b010000: res = hi;
          6'b010010: res = lo;
          default:   res = '0;
        endcase
      end
    endcase
  end

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, dvsr} : '0);
    div_sh  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_ge  = div_sh >= {1'b0, dvsr};
    div_dif = div_sh[WIDTH-1:0] - dvsr;
    div_rem = div_ge ? div_dif : div_sh[WIDTH-1:0];
  end

  // Divide by zero leaves the quotient all ones; the remainder correction
  // then restores the original dividend into HI.
  always_comb begin
    prod_fix = neg_q ? -acc : acc;
    if (is_div) begin
      done_lo = div0 ? '1 : (neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
      done_hi = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end else begin
      done_lo = prod_fix[WIDTH-1:0];
      done_hi = prod_fix[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept && is_md) state_nx = funct[1] ? DIV : MUL;
      MUL,
      DIV:     if (count == SH_W'(WIDTH-1)) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == IDLE) && (!out_valid || out_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count      <= '0;
      acc        <= '0;
      dvsr       <= '0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      div0       <= 1'b0;
      is_div     <= 1'b0;
      hi         <= '0;
      lo         <= '0;
      alu_result <= '0;
      zero       <= 1'b1;
      out_valid  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept && is_md) begin
          count  <= '0;
          acc    <= {{WIDTH{1'b0}}, a_mag};
          dvsr   <= b_mag;
          neg_q  <= a_neg ^ b_neg;
          neg_r  <= a_neg;
          div0   <= (b == '0);
          is_div <= funct[1];
        end
        MUL: begin
          acc   <= {mul_sum, acc[WIDTH-1:1]};
          count <= count + 1'b1;
        end
        DIV: begin
          acc   <= {div_rem, acc[WIDTH-2:0], div_ge};
          count <= count + 1'b1;
        end
        default: begin
          hi <= done_hi;
          lo <= done_lo;
        end
      endcase

      if (accept && !is_md) begin
        alu_result <= res;
        zero       <= (res == '0);
        out_valid  <= 1'b1;
      end else if (state == DONE) begin
        alu_result <= done_lo;
        zero       <= (done_lo == '0);
        out_valid  <= 1'b1;
      end else if (out_ready) begin
        out_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_execute_mc.sv
// Directed plus randomized bench for execute_mc, checked against an
// arithmetic reference model with immediate assertions.
module tb_execute_mc;
  localparam int W = 32;

  logic         clk = 1'b0, rst_n = 1'b0;
  logic         in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, zero, alu_src = 1'b0;
  logic [W-1:0] read_data1 = '0, read_data2 = '0, immediate = '0, alu_result, hi, lo;
  logic [5:0]   funct = '0;
  logic [2:0]   alu_op = '0;

  int           total = 0, passed = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0;
  logic [5:0]   fn_tab [18] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd38, 6'd39, 6'd42, 6'd43, 6'd0,
                                6'd2, 6'd3, 6'd16, 6'd18, 6'd24, 6'd25, 6'd26, 6'd27, 6'd63};

  execute_mc #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .read_data1(read_data1), .read_data2(read_data2), .immediate(immediate),
    .funct(funct), .alu_op(alu_op), .alu_src(alu_src), .out_valid(out_valid),
    .out_ready(out_ready), .alu_result(alu_result), .zero(zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [W-1:0] ref_single(input logic [2:0] op, input logic [5:0] fn,
                                              input logic [W-1:0] a, input logic [W-1:0] b,
                                              input int sh);
    int sa, sb;
    sa = a; sb = b;
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd3: return a & b;
      3'd4: return a | b;
      3'd5: return (sa < sb) ? 1 : 0;
      3'd6: return b * 65536;
      3'd7: return a ^ b;
      default: case (fn)
        6'd32: return a + b;
        6'd34: return a - b;
        6'd36: return a & b;
        6'd37: return a | b;
        6'd38: return a ^ b;
        6'd39: return ~(a | b);
        6'd42: return (sa < sb) ? 1 : 0;
        6'd43: return (a < b) ? 1 : 0;
        6'd0:  return b * (2 ** sh);
        6'd2:  return b / (2 ** sh);
        6'd3:  return (b / (2 ** sh)) | (b[W-1] ? ~(32'hFFFF_FFFF / (2 ** sh)) : 32'h0);
        6'd16: return m_hi;
        6'd18: return m_lo;
        default: return '0;
      endcase
    endcase
  endfunction

  task automatic ref_md(input logic [5:0] fn, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] h, output logic [W-1:0] l);
    int sa, sb;
    longint la, lb;
    logic [63:0] p;
    sa = a; sb = b; la = sa; lb = sb;
    p = '0;
    case (fn)
      6'd24: p = la * lb;
      6'd25: p = {32'h0, a} * {32'h0, b};
      default: ;
    endcase
    h = p[63:32]; l = p[31:0];
    if (fn == 6'd26 || fn == 6'd27) begin
      if (b == 0) begin l = '1; h = a; end
      else if (fn == 6'd26 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin l = a; h = 0; end
      else if (fn == 6'd26) begin l = sa / sb; h = sa % sb; end
      else begin l = a / b; h = a % b; end
    end
  endtask

  task automatic do_op(input string tag, input logic [2:0] op, input logic [5:0] fn,
                       input logic src, input logic [W-1:0] a, input logic [W-1:0] rd2,
                       input logic [W-1:0] imm);
    logic [W-1:0] b, exp, eh, el;
    bit md, ir_bad;
    int t, cyc;
    b  = src ? imm : rd2;
    md = (op == 3'd2) && (fn inside {6'd24, 6'd25, 6'd26, 6'd27});
    alu_op = op; funct = fn; alu_src = src; read_data1 = a; read_data2 = rd2; immediate = imm;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 200) begin @(posedge clk); #1; t++; end
    chk({tag, " in_ready"}, W'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (!md) begin
      exp = ref_single(op, fn, a, b, int'(imm[10:6]));
      chk({tag, " out_valid"}, W'(out_valid), 1);
      chk({tag, " result"}, alu_result, exp);
      chk({tag, " zero"}, W'(zero), W'(exp == 0));
    end else begin
      ref_md(fn, a, b, eh, el);
      cyc = 0; ir_bad = 0;
      while (!out_valid && cyc < 100) begin
        if (in_ready) ir_bad = 1;
        @(posedge clk); #1; cyc++;
      end
      chk({tag, " latency"}, cyc, W + 1);
      chk({tag, " busy"}, W'(ir_bad), 0);
      chk({tag, " hi"}, hi, eh);
      chk({tag, " lo"}, lo, el);
      chk({tag, " result"}, alu_result, el);
      chk({tag, " ready_back"}, W'(in_ready), 1);
      m_hi = eh; m_lo = el;
    end
  endtask

  initial begin
    logic [2:0]   op;
    logic [5:0]   fn;
    logic         src;
    logic [W-1:0] a, rd2, imm, held;
    bit           bad;

    #12;
    chk("rst out_valid", W'(out_valid), 0);
    chk("rst hi", hi, 0);
    chk("rst lo", lo, 0);
    chk("rst in_ready", W'(in_ready), 1);
    chk("rst result", alu_result, 0);
    chk("rst zero", W'(zero), 1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    do_op("add", 3'd0, 6'd0, 1'b0, 5, 7, 0);
    chk("add const", alu_result, 12);
    @(posedge clk); #1;
    chk("out_valid fall", W'(out_valid), 0);
    do_op("sub", 3'd2, 6'd34, 1'b0, 9, 9, 0);
    do_op("sra", 3'd2, 6'd3, 1'b0, 0, 32'h8000_0000, 32'd4 << 6);
    chk("sra const", alu_result, 32'hF800_0000);
    do_op("sltu", 3'd2, 6'd43, 1'b0, 1, 32'hFFFF_FFFF, 0);
    do_op("lui", 3'd6, 6'd0, 1'b1, 0, 0, 32'h0000_1234);
    do_op("mult", 3'd2, 6'd24, 1'b0, -32'sd3, 7, 0);
    chk("mult hi const", hi, 32'hFFFF_FFFF);
    chk("mult lo const", lo, 32'hFFFF_FFEB);
    do_op("mfhi", 3'd2, 6'd16, 1'b0, 0, 0, 0);
    chk("mfhi const", alu_result, 32'hFFFF_FFFF);
    do_op("div", 3'd2, 6'd26, 1'b0, -32'sd7, 2, 0);
    chk("div lo const", lo, 32'hFFFF_FFFD);
    do_op("divu0", 3'd2, 6'd27, 1'b0, 10, 0, 0);
    chk("divu0 hi const", hi, 10);
    do_op("div0s", 3'd2, 6'd26, 1'b0, -32'sd9, 0, 0);
    do_op("divmin", 3'd2, 6'd26, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op("multu", 3'd2, 6'd25, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);

    // Backpressure: result must hold while downstream stalls.
    @(posedge clk); #1;
    out_ready = 1'b0;
    alu_op = 3'd0; alu_src = 1'b0; read_data1 = 100; read_data2 = 23; in_valid = 1'b1;
    @(posedge clk); #1;
    held = alu_result;
    chk("bp first", held, 123);
    alu_op = 3'd7; read_data1 = 32'h0F0F_0F0F; read_data2 = 32'h00FF_00FF;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (alu_result !== held || out_valid !== 1'b1 || in_ready !== 1'b0) bad = 1;
    end
    chk("bp hold", W'(bad), 0);
    out_ready = 1'b1; #1;
    chk("bp release ready", W'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp next result", alu_result, 32'h0FF0_0FF0);
    chk("bp next valid", W'(out_valid), 1);

    for (int i = 0; i < 30; i++) begin
      op = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) op = 3'd2;
      fn  = fn_tab[$urandom_range(0, 17)];
      src = 1'($urandom_range(0, 1));
      a = $urandom; rd2 = $urandom; imm = $urandom;
      if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 20)) - 10;
      if ($urandom_range(0, 3) == 0) rd2 = 32'($urandom_range(0, 20)) - 10;
      if ($urandom_range(0, 7) == 0) begin rd2 = 0; imm = 0; end
      do_op("rand", op, fn, src, a, rd2, imm);
    end

    // Reset in the middle of a DIVU must abort with no stale result.
    @(posedge clk); #1;
    alu_op = 3'd2; funct = 6'd27; alu_src = 1'b0; read_data1 = 1000; read_data2 = 7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort hi", hi, 0);
    chk("abort lo", lo, 0);
    chk("abort out_valid", W'(out_valid), 0);
    chk("abort in_ready", W'(in_ready), 1);
    m_hi = '0; m_lo = '0;
    @(negedge clk) rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) bad = 1;
    end
    chk("abort no stale", W'(bad), 0);
    do_op("mflo after abort", 3'd2, 6'd18, 1'b0, 0, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/execute_mc.md
# execute_mc

Parametrised, handshaked execute stage for the MIPS datapath. It replaces the single-cycle combinational execute with a registered stage. Operand-2 selection and ALU-control decode are kept. It adds an iterative multiply/divide unit with HI/LO registers and valid/ready flow control on both sides. It sits between decode/register-read and the memory stage.

## Interface
- WIDTH, 32: datapath width in bits. Must be a power of two, 8 or more.
- SH_W, $clog2(WIDTH): shift-amount width.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream presents an operation.
- in_ready  out  1  stage can accept an operation this cycle.
- read_data1  in  WIDTH  operand 1 (rs).
- read_data2  in  WIDTH  operand 2 (rt).
- immediate  in  WIDTH  sign/zero-extended immediate. Bits [6+SH_W-1:6] are shamt.
- funct  in  6  instruction funct field.
- alu_op  in  3  ALU operation class.
- alu_src  in  1  selects the second operand: 0 = read_data2, 1 = immediate.
- out_valid  out  1  result register holds a valid result.
- out_ready  in  1  downstream accepts the result.
- alu_result  out  WIDTH  registered result.
- zero  out  1  registered flag, equal to (alu_result == 0).
- hi, lo  out  WIDTH each  architectural HI/LO registers.

## Operation
- Operand b = alu_src ? immediate : read_data2.
- alu_op decode:
  - 000 ADD, 001 SUB, 011 AND, 100 OR, 101 SLT, 110 LUI (b << 16), 111 XOR.
  - 010 selects R-type decode by funct.
- R-type funct codes:
  - 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR.
  - 101010 SLT (signed), 101011 SLTU.
  - 000000 SLL, 000010 SRL, 000011 SRA: operate on b, shifted by shamt.
  - 010000 MFHI, 010010 MFLO.
  - 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU.
  - Any other funct gives result 0 and still completes.
- Arithmetic wraps modulo 2^WIDTH. No overflow trap.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE: a single-cycle op is accepted on (in_valid && in_ready) and loads the result register.
  - A MULT/DIV op latches the operand magnitudes and signs, then enters MUL or DIV with count = 0.
  - MUL: shift-add, one bit per cycle, 2·WIDTH-bit product.
  - DIV: restoring division, one quotient bit per cycle.
  - After WIDTH iterations the FSM enters DONE.
  - DONE: apply sign correction, write HI/LO, load alu_result = new LO, set out_valid, return to IDLE.
- MULT/MULTU: HI = upper half of the product, LO = lower half.
- DIV/DIVU: LO = quotient, HI = remainder.
  - Signed quotient truncates toward zero. Remainder takes the sign of the dividend.
  - Divide by zero: LO = all ones, HI = dividend (as given). Signed case: same values, no sign correction.
  - Most-negative ÷ −1: LO = most-negative, HI = 0.
- in_ready = (state == IDLE) && (!out_valid || out_ready).
- While out_valid && !out_ready, the result and zero outputs hold stable.
- out_valid falls on a cycle where out_ready is high and no new result is loaded.
- MFHI/MFLO issued immediately after a MULT/DIV see the updated HI/LO. Ordering is guaranteed because in_ready is low until DONE.

## Timing
- Reset (asynchronous assert, synchronous deassert handled upstream):
  - state = IDLE, out_valid = 0, alu_result = 0, zero = 1, hi = lo = 0, iteration registers = 0.
  - After reset, in_ready = 1.
- Single-cycle op accepted at edge N gives out_valid = 1 after edge N. Latency is 1 cycle.
- Back-to-back ops with out_ready held at 1 give a throughput of 1 per cycle.
- MULT/DIV accepted at edge N:
  - in_ready is 0 from N through N+WIDTH.
  - HI/LO and alu_result update, and out_valid rises, at edge N+WIDTH+1.
  - in_ready returns to 1 in the following cycle, given out_ready.
- Asserting rst_n low mid-iteration aborts the operation. HI/LO return to 0 and no partial result is emitted.
- in_valid while in_ready = 0: the operation is not accepted and upstream must hold it.

## Test plan
- After reset: out_valid = 0, hi = lo = 0, in_ready = 1. Then ADD 5 + 7 (alu_op 000, alu_src 0) → alu_result 12, zero 0, out_valid one cycle later.
- R-type SUB 9 − 9 → alu_result 0, zero 1. SRA of 0x80000000 by shamt 4 → 0xF8000000. SLTU 1 vs 0xFFFFFFFF → 1.
- MULT −3 × 7 → HI 0xFFFFFFFF, LO 0xFFFFFFEB, out_valid exactly 33 cycles after acceptance, in_ready low throughout. A following MFHI returns 0xFFFFFFFF.
- DIV −7 ÷ 2 → LO 0xFFFFFFFD, HI 0xFFFFFFFF. DIVU 10 ÷ 0 → LO 0xFFFFFFFF, HI 10. DIV 0x80000000 ÷ −1 → LO 0x80000000, HI 0.
- Backpressure: hold out_ready = 0 for 5 cycles while a result is valid → alu_result stable, in_ready 0. Release out_ready → next op accepted on the same edge.
- Pull rst_n low at iteration 10 of a DIVU → hi = lo = 0, out_valid 0, FSM back in IDLE, no stale out_valid after release.
